// File: rtl/prog_loader.sv
// Streams a program into instruction memory while holding the CPU in reset,
// then releases the CPU a fixed number of cycles after the final word lands.
module prog_loader #(
    parameter logic [9:0]  BASE_ADDR   = 10'h200,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [9:0]        imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [10:0]       word_count
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HOLD  = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_next;
    logic [CNT_W-1:0]    count_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic                accept_c;

    // Next-state and datapath update; the pointer saturates at the top of memory.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        count_next = word_count;
        hold_next  = hold_cnt;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                if (in_valid) begin
                    accept_c   = 1'b1;
                    count_next = word_count + CNT_W'(1);
                    if (ptr != '1) ptr_next = ptr + ADDR_W'(1);
                    if (in_last) begin
                        state_next = HOLD;
                        hold_next  = '0;
                    end else if (ptr == '1) begin
                        state_next = ERROR;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) state_next = RUN;
                else hold_next = hold_cnt + HOLD_W'(1);
            end
            default: begin
            end
        endcase
    end

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= BASE_ADDR;
            word_count <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            in_ready   <= 1'b0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            word_count <= count_next;
            hold_cnt   <= hold_next;
            imem_we    <= accept_c;
            if (accept_c) begin
                imem_addr  <= ptr;
                imem_wdata <= in_data;
            end
            in_ready   <= (state_next == LOAD);
            cpu_reset  <= (state_next != RUN);
            done       <= (state_next == RUN);
            err        <= (state_next == ERROR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes go into a queue that a
// negedge monitor drains; status outputs are checked inline.
module tb_prog_loader;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HOLD   = 4;

    typedef struct packed {
        logic [9:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [9:0]        imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              err;
    logic [10:0]       word_count;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    wr_t mon_exp;

    prog_loader #(.BASE_ADDR(10'h200), .HOLD_CYCLES(HOLD), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("write_addr", 64'(imem_addr), 64'(mon_exp.addr));
                chk("write_data", 64'(imem_wdata), 64'(mon_exp.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"},        64'(imem_we),    64'(0));
        chk({tag, "_addr"},      64'(imem_addr),  64'(10'h200));
        chk({tag, "_wdata"},     64'(imem_wdata), 64'(0));
        chk({tag, "_cpu_reset"}, 64'(cpu_reset),  64'(1));
        chk({tag, "_done"},      64'(done),       64'(0));
        chk({tag, "_err"},       64'(err),        64'(0));
        chk({tag, "_count"},     64'(word_count), 64'(0));
        chk({tag, "_ready"},     64'(in_ready),   64'(0));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic last, input logic [9:0] a);
        wr_t w;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        w.addr   = a;
        w.data   = d;
        exp_q.push_back(w);
        tick();
    endtask

    // Called right after the final acceptance edge; release lands HOLD edges later.
    task automatic check_hold(input string tag);
        for (int i = 1; i < int'(HOLD); i++) begin
            tick();
            chk({tag, "_hold_cpu_reset"}, 64'(cpu_reset), 64'(1));
            chk({tag, "_hold_done"},      64'(done),      64'(0));
        end
        tick();
        chk({tag, "_run_cpu_reset"}, 64'(cpu_reset), 64'(0));
        chk({tag, "_run_done"},      64'(done),      64'(1));
        chk({tag, "_run_ready"},     64'(in_ready),  64'(0));
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check_reset_vals("por");

        // Back-to-back load of seven words, then start/valid noise in RUN.
        do_start();
        chk("b2b_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 7; i++)
            send_word(DATA_W'(32'hA0 + i), i == 6, 10'(10'h200 + i));
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("b2b_count", 64'(word_count), 64'(7));
        check_hold("b2b");
        start    = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        repeat (3) tick();
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("run_noise_count", 64'(word_count), 64'(7));
        chk("run_noise_done",  64'(done),       64'(1));
        chk("run_noise_cpu",   64'(cpu_reset),  64'(0));

        // Valid in IDLE is ignored; then a gapped load with valid held high in HOLD.
        do_reset();
        check_reset_vals("rst2");
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("idle_valid_count", 64'(word_count), 64'(0));
        do_start();
        for (int i = 0; i < 7; i++) begin
            send_word(DATA_W'(32'hA0 + i), i == 6, 10'(10'h200 + i));
            if (i < 6) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_last  = 1'b0;
        in_data  = 32'hDEAD;
        chk("gap_count", 64'(word_count), 64'(7));
        check_hold("gap");
        in_valid = 1'b0;
        chk("gap_hold_valid_count", 64'(word_count), 64'(7));

        // Overrun: 512 words without last ends in ERROR at the top address.
        do_reset();
        do_start();
        for (int i = 0; i < 512; i++)
            send_word(DATA_W'(32'h1000 + i), 1'b0, 10'(10'h200 + i));
        chk("ovr_err",   64'(err),        64'(1));
        chk("ovr_cpu",   64'(cpu_reset),  64'(1));
        chk("ovr_ready", 64'(in_ready),   64'(0));
        chk("ovr_count", 64'(word_count), 64'(512));
        start = 1'b1;
        repeat (3) tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("ovr_hold_err",   64'(err),        64'(1));
        chk("ovr_hold_count", 64'(word_count), 64'(512));
        chk("ovr_hold_done",  64'(done),       64'(0));

        // Final word exactly at the top address is legal.
        do_reset();
        do_start();
        for (int i = 0; i < 512; i++)
            send_word(DATA_W'(32'h2000 + i), i == 511, 10'(10'h200 + i));
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("top_err", 64'(err), 64'(0));
        check_hold("top");

        // Reset mid-load suppresses the write presented on the same edge.
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++)
            send_word(DATA_W'(32'hA0 + i), 1'b0, 10'(10'h200 + i));
        in_valid = 1'b1;
        in_data  = 32'hA3;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_reset_vals("midrst");
        do_start();
        send_word(32'hB0, 1'b0, 10'h200);
        send_word(32'hB1, 1'b1, 10'h201);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("reload_count", 64'(word_count), 64'(2));
        check_hold("reload");

        tick();
        tick();
        chk("pending_writes", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001: Parameter BASE_ADDR, 10'h200, instruction-memory word address of the first loaded instruction.
REQ-002: Parameter HOLD_CYCLES, 4, cycles cpu_reset stays high after the last word is written (legal range 1..15).
REQ-003: Parameter DATA_W, 32, instruction word width.
REQ-004: clk  input  1  single system clock; all state changes on the rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-007: in_valid  input  1  upstream word valid.
REQ-008: in_ready  output  1  loader can accept a word; high only in LOAD.
REQ-009: in_data  input  DATA_W  instruction word.
REQ-010: in_last  input  1  marks the final word of the program; qualified by in_valid.
REQ-011: imem_we  output  1  registered one-cycle write strobe to the instruction memory.
REQ-012: imem_addr  output  10  registered write address.
REQ-013: imem_wdata  output  DATA_W  registered write data.
REQ-014: cpu_reset  output  1  registered reset to the CPU; high until the program is loaded and settled.
REQ-015: done  output  1  program loaded and CPU released.
REQ-016: err  output  1  load overran the top of instruction memory.
REQ-017: word_count  output  11  number of words accepted since reset.

Function
REQ-018: The loader SHALL implement states IDLE, LOAD, HOLD, RUN and ERROR, held in a registered state variable.
REQ-019: IDLE -> LOAD on a clock edge with start=1; all other inputs ignored in IDLE.
REQ-020: A word SHALL be accepted on a clock edge where state=LOAD and in_valid=1 (in_ready=1 in LOAD, derived from state only).
REQ-021: On acceptance at edge k: imem_we=1, imem_addr=current write pointer, imem_wdata=in_data, all visible during the cycle after edge k; the pointer and word_count SHALL each increment by one.
REQ-022: imem_we SHALL be 0 in every cycle not immediately following an acceptance; in_valid while in_ready=0 SHALL cause no write and no count change.
REQ-023: The write pointer SHALL start at BASE_ADDR and advance by 1 per accepted word.
REQ-024: Accepting a word with in_last=1 SHALL move LOAD -> HOLD at the same edge; that word is still written.
REQ-025: Accepting a word at pointer 10'h3FF with in_last=0 SHALL write it, then move LOAD -> ERROR; the pointer SHALL NOT wrap to 0.
REQ-026: A word at 10'h3FF with in_last=1 is a legal final word and SHALL move to HOLD.
REQ-027: HOLD SHALL last exactly HOLD_CYCLES cycles, counted by an internal counter cleared on entry; cpu_reset SHALL fall and done SHALL rise at the edge ending the last HOLD cycle, entering RUN.
REQ-028: RUN: cpu_reset=0, done=1, in_ready=0; start, in_valid and in_last are ignored; the state is left only by reset.
REQ-029: ERROR: err=1, cpu_reset=1, in_ready=0, done=0; the state is left only by reset.
REQ-030: start asserted in LOAD, HOLD, RUN or ERROR SHALL have no effect.
REQ-031: A load with zero words accepted SHALL remain in LOAD indefinitely with cpu_reset=1.

Reset
REQ-032: With reset=1 at a clock edge: state=IDLE, pointer=BASE_ADDR, word_count=0, hold counter=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_reset=1, done=0, err=0.
REQ-033: reset SHALL take priority over every other input, including mid-load, mid-HOLD and in RUN/ERROR; a write pending from the same edge SHALL be suppressed.

Verification
REQ-034: start, then 7 words 0xA0..0xA6 back-to-back with in_last on the 7th -> writes to 0x200..0x206 on 7 consecutive cycles, word_count=7, cpu_reset falls exactly 4 cycles after the last acceptance edge, done=1.
REQ-035: Same 7 words with in_valid toggled 1,0,1,0... -> identical memory contents, no write in gap cycles, word_count=7.
REQ-036: 512 words without in_last -> the 512th is written at 0x3FF, err=1 next cycle, cpu_reset stays 1, in_ready=0, no further writes.
REQ-037: reset pulsed after 3 of 7 words are accepted -> all outputs return to reset values next cycle; a fresh start and 2-word load then writes 0x200 and 0x201.
REQ-038: start pulsed in RUN, and in_valid=1 in IDLE/HOLD -> no writes, word_count, done and cpu_reset unchanged.
